// File: rtl/bram_dual_one_clk.sv
// Simple dual-port block RAM on one clock: port A writes, port B reads into a
// registered output that holds its value whenever enb is low.
module bram_dual_one_clk #(
  parameter int DATA_WITH  = 16,
  parameter int DATA_DEPTH = 1024
) (
  input  logic                          clk,
  input  logic                          ena,
  input  logic                          enb,
  input  logic                          wea,
  input  logic [$clog2(DATA_DEPTH)-1:0] addra,
  input  logic [$clog2(DATA_DEPTH)-1:0] addrb,
  input  logic [DATA_WITH-1:0]          dia,
  output logic [DATA_WITH-1:0]          dob
);

  logic [DATA_WITH-1:0] r_mem [DATA_DEPTH];

  // NOTE: the array and dob carry no reset so the storage maps onto block RAM;
  // a reset term here would force it into flip-flops.
  always_ff @(posedge clk) begin
    if (ena && wea) r_mem[addra] <= dia;
    if (enb)        dob          <= r_mem[addrb];
  end

endmodule

// File: rtl/fwft_sync_fifo.sv
// First-word-fall-through synchronous FIFO: the RAM read register is the
// output stage, so capacity is DATA_DEPTH RAM words plus one in flight.
module fwft_sync_fifo #(
  parameter int DATA_WITH  = 16,
  parameter int DATA_DEPTH = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_WITH-1:0]            s_data,
  input  logic                            s_valid,
  output logic                            s_ready,
  output logic [DATA_WITH-1:0]            m_data,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [$clog2(DATA_DEPTH+2)-1:0] level
);

  localparam int AW = $clog2(DATA_DEPTH);
  localparam int CW = $clog2(DATA_DEPTH + 2);

  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_ram_count, r_level;
  logic          r_m_valid, r_s_ready;

  logic          w_wr, w_pf, w_m_valid_next;
  logic [CW-1:0] w_ram_count_next;

  assign w_wr = s_valid && r_s_ready;
  // Reload the output register whenever it is empty or being consumed.
  assign w_pf = (r_ram_count != '0) && (!r_m_valid || m_ready);

  // NOTE: every combinational output gets a default before the branches so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    w_ram_count_next = r_ram_count;
    case ({w_wr, w_pf})
      2'b10:   w_ram_count_next = r_ram_count + CW'(1);
      2'b01:   w_ram_count_next = r_ram_count - CW'(1);
      default: w_ram_count_next = r_ram_count;
    endcase
    w_m_valid_next = w_pf ? 1'b1 : (m_ready ? 1'b0 : r_m_valid);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_ram_count <= '0;
      r_m_valid   <= 1'b0;
      r_level     <= '0;
      r_s_ready   <= 1'b1;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pf) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_ram_count <= w_ram_count_next;
      r_m_valid   <= w_m_valid_next;
      r_level     <= w_ram_count_next + CW'(w_m_valid_next);
      // Registered from the next count: no path from m_ready/s_valid to s_ready.
      r_s_ready   <= w_ram_count_next < CW'(DATA_DEPTH);
    end
  end

  bram_dual_one_clk #(
    .DATA_WITH  (DATA_WITH),
    .DATA_DEPTH (DATA_DEPTH)
  ) u_bram (
    .clk   (clk),
    .ena   (w_wr),
    .enb   (w_pf),
    .wea   (w_wr),
    .addra (r_wr_ptr),
    .addrb (r_rd_ptr),
    .dia   (s_data),
    .dob   (m_data)
  );

  assign s_ready = r_s_ready;
  assign m_valid = r_m_valid;
  assign level   = r_level;

endmodule

// File: tb/tb_fwft_sync_fifo.sv
// Randomized self-checking bench for fwft_sync_fifo against a queue model that
// tracks each word's accept cycle.
module tb_fwft_sync_fifo;

  localparam int DW = 16;
  localparam int DD = 4;
  localparam int LW = $clog2(DD + 2);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [LW-1:0] level;

  always #5 clk = ~clk;

  fwft_sync_fifo #(.DATA_WITH(DW), .DATA_DEPTH(DD)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .level   (level)
  );

  typedef struct {
    logic [DW-1:0] d;
    int            c;
  } entry_t;

  entry_t q[$];
  int     cyc       = 0;
  int     n_checks  = 0;
  int     n_errors  = 0;
  int     n_written = 0;
  int     n_read    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the model.
  // A word is visible at the head once it has been held for two full cycles.
  task automatic step(input logic sv, input logic [DW-1:0] d, input logic mr,
                      input logic r, input bit chk);
    bit exp_mv, exp_sr, wr, rd;
    int exp_rc;
    s_valid = sv;
    s_data  = d;
    m_ready = mr;
    rst     = r;
    #1;
    exp_mv = (q.size() > 0) && (q[0].c <= cyc - 2);
    exp_rc = q.size() - int'(exp_mv);
    exp_sr = exp_rc < DD;
    if (chk) begin
      check("m_valid", 32'(m_valid), 32'(exp_mv));
      check("level",   32'(level),   32'(q.size()));
      check("s_ready", 32'(s_ready), 32'(exp_sr));
      if (exp_mv) check("m_data", 32'(m_data), 32'(q[0].d));
    end
    wr = sv && exp_sr;
    rd = exp_mv && mr;
    @(posedge clk);
    if (r) begin
      q.delete();
    end else begin
      if (rd) begin
        void'(q.pop_front());
        n_read++;
      end
      if (wr) begin
        q.push_back('{d: d, c: cyc});
        n_written++;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    logic [DW-1:0] held;
    int            accepted;

    // Power-up reset, then reset-state checks.
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_level",   32'(level),   32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd1);

    // Single word: level 0 -> 1 -> 1 -> 0, visible two cycles after acceptance.
    step(1'b1, 16'hA5A5, 1'b1, 1'b0, 1'b1);
    check("single_lvl1", 32'(level), 32'd1);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    check("single_valid", 32'(m_valid), 32'd1);
    check("single_data",  32'(m_data),  32'hA5A5);
    check("single_lvl2",  32'(level),   32'd1);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    check("single_gone", 32'(m_valid), 32'd0);
    check("single_lvl3", 32'(level),   32'd0);

    // Fill with the consumer stalled: 5 of 6 words fit.
    accepted = n_written;
    for (int i = 1; i <= 6; i++) step(1'b1, DW'(i), 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("fill_accepted", 32'(n_written - accepted), 32'd5);
    check("fill_level",    32'(level),   32'd5);
    check("fill_s_ready",  32'(s_ready), 32'd0);
    check("fill_head",     32'(m_data),  32'h0001);

    // Drain 0x0001..0x0005 back to back.
    for (int i = 1; i <= 5; i++) begin
      check("drain_data", 32'(m_data), 32'(i));
      step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    end
    check("drain_empty", 32'(m_valid), 32'd0);
    check("drain_level", 32'(level),   32'd0);

    // Streaming: one word per cycle, level never above 2.
    accepted = n_read;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, DW'(16'h1000 + i), 1'b1, 1'b0, 1'b1);
      if (level > 2) check("stream_level", 32'(level), 32'd2);
    end
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    check("stream_count", 32'(n_read - accepted), 32'd20);

    // Wrap and stall: 10 words with random consumer gaps; head held while stalled.
    accepted = n_written;
    for (int i = 0; i < 200 && (n_written - accepted) < 10; i++) begin
      logic mr;
      mr   = 1'($urandom_range(0, 2) == 0);
      held = m_data;
      if (m_valid && !mr) begin
        step(1'b1, DW'(16'h2000 + n_written - accepted), mr, 1'b0, 1'b1);
        check("stall_hold", 32'(m_data), 32'(held));
      end else begin
        step(1'b1, DW'(16'h2000 + n_written - accepted), mr, 1'b0, 1'b1);
      end
    end
    check("wrap_written", 32'(n_written - accepted), 32'd10);
    for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b1);

    // Fully random traffic.
    for (int i = 0; i < 300; i++)
      step(1'($urandom), DW'($urandom), 1'($urandom_range(0, 3) != 0), 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b1);

    // Reset mid-stream at level 3; the next word must come out first.
    for (int i = 0; i < 10 && q.size() < 3; i++) step(1'b1, DW'(16'h3000 + i), 1'b0, 1'b0, 1'b1);
    check("pre_rst_level", 32'(level), 32'd3);
    step(1'b1, 16'h3333, 1'b1, 1'b1, 1'b1);
    check("post_rst_valid", 32'(m_valid), 32'd0);
    check("post_rst_level", 32'(level),   32'd0);
    check("post_rst_ready", 32'(s_ready), 32'd1);
    step(1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("beef_valid", 32'(m_valid), 32'd1);
    check("beef_data",  32'(m_data),  32'hBEEF);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    check("final_level", 32'(level), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
